usb_bus_arbiter: RTL and testbench

- Two-requester arbiter in front of the USB controller bus bridge (the picorv-side 16-bit async bus engine).
- Port 0 is the CPU data bus; port 1 is the USB packet/DMA engine.
- Serialises their accesses onto the bridge's single valid/ready master interface, with round-robin fairness, registered responses and an optional hang watchdog.

---
 rtl/usb_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_usb_bus_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_arbiter.sv
// Two-port round-robin arbiter serialising CPU (port 0) and USB DMA (port 1)
// accesses onto the bridge master. Define USB_ARB_TIMEOUT_EN to add the hang watchdog.
module usb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_valid,
  output logic        s0_ready,
  output logic [31:0] s0_rdata,
  input  logic [18:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [31:0] s1_rdata,
  output logic [18:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  state_t            state;
  logic              win;
  logic              expire;
  logic              resp_fire;
  logic [DATA_W-1:0] resp_data;

  // On a tie the port that did not win last time is served.
  function automatic logic pick_port(input logic v0, input logic v1, input logic last);
    logic sel;
    sel = v1;
    if (v0 && v1) sel = ~last;
    return sel;
  endfunction

  assign win       = pick_port(s0_valid, s1_valid, grant);
  assign resp_fire = (state == ISSUE) && (m_ready || expire);
  assign resp_data = m_ready ? m_rdata : TIMEOUT_RDATA;

`ifdef USB_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // A bridge ready in the expiry cycle wins over the abort.
  assign expire = (state == ISSUE) && !m_ready &&
                  (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && (s0_valid || s1_valid)) tmo_cnt <= '0;
      else if (state == ISSUE)                     tmo_cnt <= tmo_cnt + 8'd1;
      if (expire) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire             = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      s0_rdata <= '0;
      s1_rdata <= '0;
      grant    <= 1'b1;
      busy     <= 1'b0;
    end else begin
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            grant   <= win;
            m_addr  <= win ? s1_addr  : s0_addr;
            m_wdata <= win ? s1_wdata : s0_wdata;
            m_wstrb <= win ? s1_wstrb : s0_wstrb;
            m_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (resp_fire) begin
            m_valid <= 1'b0;
            if (grant) begin
              s1_rdata <= resp_data;
              s1_ready <= 1'b1;
            end else begin
              s0_rdata <= resp_data;
              s0_ready <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: state <= GAP;
        // Extra cycle so the requester can drop valid before re-arbitration.
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bus_arbiter.sv
// Self-checking bench for usb_bus_arbiter: bridge model, transaction-level
// scoreboard, directed vector table, corner sequences and random traffic.
module tb_usb_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] s0_addr = '0, s1_addr = '0;
  logic [31:0] s0_wdata = '0, s1_wdata = '0;
  logic [3:0]  s0_wstrb = '0, s1_wstrb = '0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [18:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        grant, busy, timeout_err;

  usb_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_valid(s0_valid),
    .s0_ready(s0_ready), .s0_rdata(s0_rdata),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_valid(s1_valid),
    .s1_ready(s1_ready), .s1_rdata(s1_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_valid(m_valid),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n      = 0;

  // Bridge model: write ready 1 cycle after m_valid, read ready after 6.
  bit          mute = 0, spur = 0, ovr_en = 0;
  logic [31:0] ovr_data = '0;
  int          br_cnt = 0;

  function automatic logic [31:0] mem_f(input logic [18:0] a);
    return ({13'h0, a} * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst) begin
      br_cnt  = 0;
      m_ready = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b0;
      br_cnt  = 0;
    end else if (m_valid && !mute) begin
      br_cnt++;
      if (br_cnt >= ((m_wstrb != 4'h0) ? 1 : 6)) begin
        m_ready = 1'b1;
        m_rdata = ovr_en ? ovr_data : mem_f(m_addr);
      end
    end else begin
      br_cnt = 0;
    end
    if (!m_ready) m_rdata = $urandom;
    if (spur) begin
      m_ready = 1'b1;
      spur    = 0;
    end
  end

  // Transaction-level reference: one outstanding access, round-robin ties,
  // response visible the cycle after completion, re-arbitration 3 cycles later.
  bit          pend, last, rport, e_terr;
  int          issue_n, done_n;
  logic [18:0] e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic [3:0]  e_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    pend    = 0;
    last    = 1;
    e_terr  = 0;
    issue_n = -1000;
    done_n  = -1000;
  endtask

  task automatic predict();
    bit w;
    if (!pend && n >= done_n + 3 && (s0_valid || s1_valid)) begin
      w       = (s0_valid && s1_valid) ? !last : s1_valid;
      last    = w;
      pend    = 1;
      issue_n = n;
      e_addr  = w ? s1_addr  : s0_addr;
      e_wdata = w ? s1_wdata : s0_wdata;
      e_wstrb = w ? s1_wstrb : s0_wstrb;
    end
  endtask

  task automatic check_cycle();
    bit mv_exp, busy_exp, resp;
    mv_exp   = pend && n > issue_n;
    busy_exp = mv_exp || (n >= done_n + 1 && n <= done_n + 2);
    resp     = (n == done_n + 1);
    chk("m_valid", m_valid, mv_exp);
    chk("busy", busy, busy_exp);
    chk("grant", grant, last);
    chk("timeout_err", timeout_err, e_terr);
    chk("s0_ready", s0_ready, resp && !rport);
    chk("s1_ready", s1_ready, resp && rport);
    if (resp) chk("s_rdata", rport ? s1_rdata : s0_rdata, e_rdata);
    if (mv_exp) begin
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      chk("m_wstrb", m_wstrb, e_wstrb);
      if (m_ready) begin
        done_n  = n;
        pend    = 0;
        rport   = last;
        e_rdata = m_rdata;
      end
`ifdef USB_ARB_TIMEOUT_EN
      else if (n == issue_n + TO) begin
        done_n  = n;
        pend    = 0;
        rport   = last;
        e_rdata = 32'hDEAD_0000;
        e_terr  = 1;
      end
`endif
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    @(negedge clk);
    n++;
    check_cycle();
  endtask

  task automatic set_req(input bit p, input logic [18:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    if (p) begin
      s1_addr = a; s1_wdata = d; s1_wstrb = s; s1_valid = 1'b1;
    end else begin
      s0_addr = a; s0_wdata = d; s0_wstrb = s; s0_valid = 1'b1;
    end
  endtask

  function automatic logic port_ready(input bit p);
    return p ? s1_ready : s0_ready;
  endfunction

  function automatic logic [31:0] port_rdata(input bit p);
    return p ? s1_rdata : s0_rdata;
  endfunction

  task automatic wait_ready(input bit p, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (port_ready(p)) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
    mute = 0; spur = 0; ovr_en = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          port;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] br_data;
    logic [31:0] exp_rdata;
    bit          exp_grant;
  } vec_t;

  vec_t tbl[6];
  bit   order[$];
  int   served[2];

  initial begin
    bit ok, saw, re0, re1, raised;
    int first;

    tbl[0] = '{1'b0, 19'h00104, 32'h0000_0000, 4'h0, 32'h0000_1234, 32'h0000_1234, 1'b0};
    tbl[1] = '{1'b1, 19'h00008, 32'h0000_ABCD, 4'hF, 32'h0000_5555, 32'h0000_5555, 1'b1};
    tbl[2] = '{1'b0, 19'h7FFFF, 32'hFFFF_FFFF, 4'h3, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0};
    tbl[3] = '{1'b1, 19'h40000, 32'h0000_0000, 4'h0, 32'h8000_0001, 32'h8000_0001, 1'b1};
    tbl[4] = '{1'b1, 19'h00000, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[5] = '{1'b0, 19'h00004, 32'h1234_5678, 4'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_s0_rdata", s0_rdata, 0);
    chk("rst_s1_rdata", s1_rdata, 0);
    chk("rst_grant", grant, 1);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Directed single transactions.
    for (int i = 0; i < 6; i++) begin
      ovr_data = tbl[i].br_data;
      ovr_en   = 1;
      set_req(tbl[i].port, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      wait_ready(tbl[i].port, 40, ok);
      chk("tbl_done", ok, 1);
      chk("tbl_rdata", port_rdata(tbl[i].port), tbl[i].exp_rdata);
      chk("tbl_grant", grant, tbl[i].exp_grant);
      if (tbl[i].port) s1_valid = 1'b0; else s0_valid = 1'b0;
      repeat (3) tick();
    end
    ovr_en = 0;

    // Spurious ready in idle, late request during completion, spurious ready in GAP.
    spur = 1;
    repeat (3) tick();
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_m_valid", m_valid, 0);
    set_req(1, 19'h00044, 32'h1111_2222, 4'hF);
    raised = 0;
    saw    = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (m_ready && s1_valid && !raised) begin
        set_req(0, 19'h00048, 32'h0, 4'h0);
        raised = 1;
      end
      if (s1_ready) begin
        s1_valid = 1'b0;
        spur     = 1;
      end
      if (s0_ready) begin
        s0_valid = 1'b0;
        saw      = 1;
        break;
      end
    end
    chk("late_req_served", saw, 1);
    chk("late_req_rdata", s0_rdata, mem_f(19'h00048));
    repeat (3) tick();

    // Tie after reset and continuous contention.
    reset_dut();
    set_req(0, 19'h00010, 32'h1, 4'hF);
    set_req(1, 19'h00020, 32'h2, 4'hF);
    re0 = 0;
    re1 = 0;
    order.delete();
    for (int i = 0; i < 200 && order.size() < 6; i++) begin
      tick();
      if (s0_ready) begin
        order.push_back(1'b0); s0_valid = 1'b0; re0 = 1;
      end else if (re0) begin
        s0_valid = 1'b1; re0 = 0;
      end
      if (s1_ready) begin
        order.push_back(1'b1); s1_valid = 1'b0; re1 = 1;
      end else if (re1) begin
        s1_valid = 1'b1; re1 = 0;
      end
    end
    chk("tie_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++) chk("tie_order", order[i], i % 2);

    // Reset during ISSUE.
    reset_dut();
    set_req(0, 19'h00104, 32'h0, 4'h0);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid) begin
        ok = 1;
        break;
      end
    end
    chk("rst_mid_issue_seen", ok, 1);
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n++;
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_s0_ready", s0_ready, 0);
    chk("rst_mid_grant", grant, 1);
    rst      = 1'b0;
    s0_valid = 1'b0;
    model_reset();
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s0_ready || s1_ready) saw = 1;
    end
    chk("rst_mid_no_ready", saw, 0);

`ifdef USB_ARB_TIMEOUT_EN
    // Watchdog abort, then a normal read.
    reset_dut();
    mute  = 1;
    first = -1;
    set_req(0, 19'h00200, 32'h0, 4'h0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_valid && first < 0) first = n;
      if (s0_ready) begin
        ok = 1;
        break;
      end
    end
    chk("tmo_done", ok, 1);
    chk("tmo_rdata", s0_rdata, 32'hDEAD_0000);
    chk("tmo_cycles", n - first, TO);
    s0_valid = 1'b0;
    mute     = 0;
    tick();
    chk("tmo_err_set", timeout_err, 1);
    repeat (2) tick();
    set_req(0, 19'h00300, 32'h0, 4'h0);
    wait_ready(0, 40, ok);
    chk("tmo_after_done", ok, 1);
    chk("tmo_after_rdata", s0_rdata, mem_f(19'h00300));
    s0_valid = 1'b0;
    tick();
    chk("tmo_err_sticky", timeout_err, 1);
    repeat (3) tick();
`else
    // Without the watchdog a silent bridge stalls the access indefinitely.
    reset_dut();
    mute = 1;
    set_req(0, 19'h00200, 32'h0, 4'h0);
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s0_ready) saw = 1;
    end
    chk("hold_no_ready", saw, 0);
    chk("hold_m_valid", m_valid, 1);
    chk("hold_no_err", timeout_err, 0);
    mute = 0;
    wait_ready(0, 20, ok);
    chk("hold_release_done", ok, 1);
    chk("hold_release_rdata", s0_rdata, mem_f(19'h00200));
    s0_valid = 1'b0;
    repeat (3) tick();
`endif

    // Random traffic on both ports against the reference.
    reset_dut();
    served[0] = 0;
    served[1] = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (port_ready(p[0])) begin
          if (p == 1) s1_valid = 1'b0; else s0_valid = 1'b0;
          served[p]++;
        end else if (i < 2470 && !(p == 1 ? s1_valid : s0_valid) &&
                     $urandom_range(0, 2) == 0) begin
          set_req(p[0], 19'($urandom), $urandom,
                  ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
        end
      end
    end
    chk("rand_port0_served", served[0] > 20, 1);
    chk("rand_port1_served", served[1] > 20, 1);
    chk("rand_drained", s0_valid || s1_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
